// File: rtl/digit_scan_mux.sv
// rtl/digit_scan_mux.sv - time-multiplexed digit scanner with snapshot, masking and leading-zero blanking
module digit_scan_mux #(
  parameter int N_DIGITS = 8,
  parameter int DIGIT_W  = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_DIGITS*DIGIT_W-1:0]   din,
  input  logic                          load,
  input  logic [N_DIGITS-1:0]           en,
  input  logic                          lz_en,
  output logic [N_DIGITS-1:0]           digit_sel,
  output logic [DIGIT_W-1:0]            digit_val,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
  output logic                          blank,
  output logic                          frame_done
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]       PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

  if (N_DIGITS < 2 || N_DIGITS > 16) begin : g_bad_n
    $error("digit_scan_mux: N_DIGITS must be 2..16");
  end
  if (SCAN_DIV < 1) begin : g_bad_div
    $error("digit_scan_mux: SCAN_DIV must be >= 1");
  end

  logic [PW-1:0]                 prescaler;
  logic                          tick;
  logic [N_DIGITS*DIGIT_W-1:0]   snap;
  logic [N_DIGITS-1:0]           suppressed;
  logic [N_DIGITS-1:0]           lit;
  logic                          upper_zero;
  logic                          cur_lit;
  logic [DIGIT_W-1:0]            cur_val;

  assign tick = (prescaler == PRE_LAST);

  // Walk from the most significant digit down; a digit is suppressed only
  // while every digit at or above it is zero. Digit 0 always stays lit.
  always_comb begin
    suppressed = '0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero    = upper_zero & (snap[i*DIGIT_W +: DIGIT_W] == '0);
      suppressed[i] = (i != 0) && lz_en && upper_zero;
    end
  end

  assign lit     = en & ~suppressed;
  assign cur_lit = lit[digit_idx];
  assign cur_val = snap[int'(digit_idx)*DIGIT_W +: DIGIT_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      digit_idx  <= '0;
      snap       <= '0;
      digit_sel  <= '0;
      digit_val  <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        snap <= din;
      end

      if (tick) begin
        prescaler <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      frame_done <= tick && (digit_idx == IDX_LAST);

      // Outputs reflect the slot that was current before this edge.
      if (cur_lit) begin
        digit_sel <= ONE_HOT0 << digit_idx;
        digit_val <= cur_val;
        blank     <= 1'b0;
      end else begin
        digit_sel <= '0;
        digit_val <= '0;
        blank     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb/tb_digit_scan_mux.sv - scoreboard bench for digit_scan_mux (N_DIGITS=4, DIGIT_W=4, SCAN_DIV=3)
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [3:0]  en;
  logic        lz_en;
  logic [3:0]  digit_sel;
  logic [3:0]  digit_val;
  logic [1:0]  digit_idx;
  logic        blank;
  logic        frame_done;

  digit_scan_mux #(.N_DIGITS(4), .DIGIT_W(4), .SCAN_DIV(3)) dut (
    .clk(clk), .reset(reset), .din(din), .load(load), .en(en), .lz_en(lz_en),
    .digit_sel(digit_sel), .digit_val(digit_val), .digit_idx(digit_idx),
    .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] val;
    logic [1:0] idx;
    logic       blank;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: after each edge, pop one expected record and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("digit_sel",  digit_sel,          e.sel);
        chk("digit_val",  digit_val,          e.val);
        chk("digit_idx",  {2'b00, digit_idx}, {2'b00, e.idx});
        chk("blank",      {3'b000, blank},    {3'b000, e.blank});
        chk("frame_done", {3'b000, frame_done}, {3'b000, e.fd});
      end
    end
  end

  task automatic step(input exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  // Frame position j (0..11) counts edges from the start of a scan frame:
  // output slot j/3 is shown, idx after the edge is (j+1)/3 mod 4, wrap pulse at j=11.
  task automatic frame(input int j0, input int j1,
                       input logic [15:0] sel_p, input logic [15:0] val_p,
                       input logic [3:0] blk, input logic do_load,
                       input logic [15:0] nd, input logic [3:0] ne, input logic nlz);
    exp_t e;
    int   s;
    for (int j = j0; j < j1; j++) begin
      s       = j / 3;
      e.sel   = sel_p[s*4 +: 4];
      e.val   = val_p[s*4 +: 4];
      e.blank = blk[s];
      e.idx   = 2'(((j + 1) / 3) % 4);
      e.fd    = (j == 11);
      step(e);
      if (j == 10 && do_load) begin
        din  = nd;
        load = 1'b1;
      end
      if (j == 11) begin
        load  = 1'b0;
        din   = 16'hFFFF;
        en    = ne;
        lz_en = nlz;
      end
    end
  endtask

  initial begin
    exp_t r;
    reset = 1'b1;
    din   = 16'h4321;
    load  = 1'b1;
    en    = 4'b1111;
    lz_en = 1'b0;

    r = '{sel: 4'h0, val: 4'h0, idx: 2'd0, blank: 1'b1, fd: 1'b0};
    step(r);
    step(r);
    reset = 1'b0;

    // First edge after reset: load lands, outputs still show the cleared snapshot.
    r = '{sel: 4'h1, val: 4'h0, idx: 2'd0, blank: 1'b0, fd: 1'b0};
    step(r);
    load = 1'b0;
    din  = 16'hFFFF;

    frame(1, 12, 16'h8421, 16'h4321, 4'b0000, 1'b0, 16'h0000, 4'b1111, 1'b0);
    frame(0, 12, 16'h8421, 16'h4321, 4'b0000, 1'b0, 16'h0000, 4'b1010, 1'b0);
    frame(0, 12, 16'h8020, 16'h4020, 4'b0101, 1'b1, 16'h0050, 4'b1111, 1'b1);
    frame(0, 12, 16'h0021, 16'h0050, 4'b1100, 1'b1, 16'h0000, 4'b1111, 1'b1);
    frame(0, 12, 16'h0001, 16'h0000, 4'b1110, 1'b1, 16'h4321, 4'b1111, 1'b1);
    frame(0, 12, 16'h8421, 16'h4321, 4'b0000, 1'b0, 16'h0000, 4'b1111, 1'b1);
    frame(0, 6,  16'h8421, 16'h4321, 4'b0000, 1'b0, 16'h0000, 4'b1111, 1'b1);

    // Mid-scan reset with digit_idx at 2.
    reset = 1'b1;
    r = '{sel: 4'h0, val: 4'h0, idx: 2'd0, blank: 1'b1, fd: 1'b0};
    step(r);
    reset = 1'b0;
    frame(0, 12, 16'h0001, 16'h0000, 4'b1110, 1'b0, 16'h0000, 4'b1111, 1'b1);

    @(posedge clk);
    #3;
    chk("queue_drained", 4'(q.size()), 4'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of time-multiplexed digit channels (legal range 2..16).
REQ-002 SHALL have parameter DIGIT_W, default 4, width of each digit value.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal range >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port din, input, N_DIGITS*DIGIT_W bits: digit i at bits [i*DIGIT_W +: DIGIT_W]; digit N_DIGITS-1 is most significant.
REQ-007 SHALL have port load, input, 1 bit: captures din into the snapshot register.
REQ-008 SHALL have port en, input, N_DIGITS bits: per-digit enable; 0 blanks that digit.
REQ-009 SHALL have port lz_en, input, 1 bit: enables leading-zero suppression.
REQ-010 SHALL have port digit_sel, output, N_DIGITS bits: one-hot, active-high select of the lit digit; all zeros when blanked.
REQ-011 SHALL have port digit_val, output, DIGIT_W bits: value of the selected digit; 0 when blanked.
REQ-012 SHALL have port digit_idx, output, $clog2(N_DIGITS) bits: current scan index.
REQ-013 SHALL have port blank, output, 1 bit: 1 when the current slot is blanked.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at each scan wrap.

Function
REQ-015 SHALL hold a prescaler counting 0..SCAN_DIV-1 and wrapping to 0; tick = (prescaler == SCAN_DIV-1); with SCAN_DIV=1, tick SHALL be asserted every cycle.
REQ-016 SHALL advance digit_idx by 1 on each tick, wrapping from N_DIGITS-1 to 0.
REQ-017 SHALL assert frame_done for exactly the one cycle in which digit_idx has just wrapped to 0; never otherwise.
REQ-018 SHALL load snap <= din at the edge where load=1; snap SHALL otherwise hold; din changes without load SHALL have no effect on the outputs.
REQ-019 SHALL compute suppression for digit i (i>0) as lz_en=1 AND snap digit i == 0 AND all snap digits above i == 0; digit 0 SHALL never be suppressed.
REQ-020 SHALL treat slot i as blanked when en[i]=0 or digit i is suppressed.
REQ-021 SHALL register digit_sel, digit_val and blank; each edge SHALL compute them from digit_idx, snap, en and lz_en as they stood before that edge (1-cycle latency after an index or snapshot change).
REQ-022 SHALL drive digit_sel = one-hot(idx prior to the edge), digit_val = snap digit at that idx and blank=0 for an unblanked slot; digit_sel=0, digit_val=0 and blank=1 for a blanked slot.
REQ-023 SHALL apply a load and a tick in the same cycle independently; the new snap value SHALL appear on the outputs one edge later.
REQ-024 SHALL sample en and lz_en live each cycle, without gating by load.

Reset
REQ-025 SHALL, at the edge where reset=1, clear prescaler, digit_idx, snap, digit_sel, digit_val and frame_done to 0 and set blank=1; reset SHALL take priority over load and tick.
REQ-026 SHALL restart the scan at index 0 with a full SCAN_DIV slot on the first edge after reset deasserts, including when reset is asserted mid-scan.

Verification (N_DIGITS=4, DIGIT_W=4, SCAN_DIV=3)
REQ-027 SHALL cover reset: reset=1 for 2 cycles -> digit_sel=0000, digit_val=0, digit_idx=0, blank=1, frame_done=0.
REQ-028 SHALL cover scan: din=16'h4321, load pulse, en=1111, lz_en=0 -> digit_sel steps 0001/0010/0100/1000, each held 3 cycles, with digit_val 1/2/3/4; frame_done pulses once every 12 cycles.
REQ-029 SHALL cover snapshot hold: after loading 16'h4321, change din to 16'hFFFF with load=0 -> digit_val sequence stays 1/2/3/4.
REQ-030 SHALL cover leading-zero suppression: load 16'h0050 with lz_en=1 -> slots 3 and 2 blank=1; slot 1 value 5; slot 0 value 0; load 16'h0000 -> only slot 0 lit, value 0.
REQ-031 SHALL cover masking: en=1010 with 16'h4321 loaded -> slots 0 and 2 blanked; slot 1 value 2; slot 3 value 4.
REQ-032 SHALL cover mid-scan reset: reset asserted for 1 cycle while digit_idx=2 -> next edge digit_idx=0 and snap=0; the scan resumes from slot 0 with all values 0.
